pru_cmd_scheduler: RTL and testbench

//  Queues two-word shape commands from the CPU bus and issues them one at a time to the PRU.
//  For each command it drives the PRU field lanes, pulses start, and waits for done before the next.

---
 rtl/pru_cmd_scheduler.sv | 166 ++++++++++++++++
 tb/tb_pru_cmd_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pru_cmd_scheduler.sv
// Two-word shape command queue feeding the PRU: stages word0, pushes on word1,
// and issues one command at a time with a start pulse, waiting for done (with watchdog).
module pru_cmd_scheduler #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       wr_addr,
    input  logic [31:0]                wr_data,
    input  logic                       flush,
    input  logic                       hold,
    input  logic                       pru_busy,
    input  logic                       pru_done,
    output logic [1:0]                 color,
    output logic [9:0]                 row,
    output logic [8:0]                 col,
    output logic [9:0]                 width,
    output logic [8:0]                 height_radius,
    output logic [1:0]                 shape_select,
    output logic                       subtract,
    output logic                       start,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       full,
    output logic                       empty,
    output logic                       idle,
    output logic                       overflow,
    output logic                       timeout_err,
    input  logic                       err_clr
);
    // state      | meaning
    // S_IDLE     | waiting for a queued command (and no hold/flush)
    // S_ISSUE    | start pulse, fields valid
    // S_WAIT_BUSY| waiting for PRU to report busy (or an early done)
    // S_WAIT_DONE| waiting for PRU done, watchdog running
    // S_DONE     | one-cycle gap before returning to idle
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [2:0]      state;
    logic [30:0]     staging;
    logic [42:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [WD_W-1:0] wdog;
    logic [30:0]     head_w0;
    logic [11:0]     head_w1;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            waiting;
    logic            wd_fire;
    logic            unused_wr_msb;

    assign unused_wr_msb = wr_data[31];

    assign {head_w0, head_w1} = mem[rd_ptr];

    assign full     = (fifo_count == CW'(DEPTH));
    assign empty    = (fifo_count == '0);
    assign idle     = (state == S_IDLE) && empty;
    assign start    = (state == S_ISSUE);
    assign push_req = wr_en && wr_addr;
    assign pop      = (state == S_IDLE) && !empty && !hold && !flush;
    // a push into a full FIFO is still accepted when the head leaves the same cycle
    assign push_ok  = push_req && !flush && (!full || pop);
    assign waiting  = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign wd_fire  = (TIMEOUT != 0) && waiting && !pru_done && (wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {staging, wr_data[11:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en && !wr_addr) begin
                staging <= wr_data[30:0];
            end
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // set events take priority over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push_req && !flush && full && !pop) overflow <= 1'b1;
            else if (err_clr)                       overflow <= 1'b0;
            if (wd_fire)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wdog          <= '0;
            color         <= '0;
            row           <= '0;
            col           <= '0;
            width         <= '0;
            height_radius <= '0;
            shape_select  <= '0;
            subtract      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        width         <= head_w0[30:21];
                        col           <= head_w0[20:12];
                        row           <= head_w0[11:2];
                        color         <= head_w0[1:0];
                        subtract      <= head_w1[11];
                        shape_select  <= head_w1[10:9];
                        height_radius <= head_w1[8:0];
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    wdog <= wdog + 1'b1;
                    if (pru_done || wd_fire) state <= S_DONE;
                    else if (pru_busy)       state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    wdog <= wdog + 1'b1;
                    if (pru_done || wd_fire) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pru_cmd_scheduler.sv
// Directed bench for pru_cmd_scheduler with a simple PRU responder model.
module tb_pru_cmd_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_addr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        err_clr = 1'b0;
    logic        pru_busy = 1'b0;
    logic        pru_done = 1'b0;
    logic [1:0]  color;
    logic [9:0]  row;
    logic [8:0]  col;
    logic [9:0]  width;
    logic [8:0]  height_radius;
    logic [1:0]  shape_select;
    logic        subtract;
    logic        start;
    logic [3:0]  fifo_count;
    logic        full, empty, idle, overflow, timeout_err;

    int checks = 0;
    int errors = 0;
    int busy_len = 3;
    bit never_done = 1'b0;
    int cnt = 0;
    int cyc = 0;
    int start_cnt = 0;
    logic [9:0] log_row [64];
    int log_cyc [64];

    pru_cmd_scheduler #(.DEPTH(8), .TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .hold(hold), .pru_busy(pru_busy), .pru_done(pru_done),
        .color(color), .row(row), .col(col), .width(width), .height_radius(height_radius),
        .shape_select(shape_select), .subtract(subtract), .start(start),
        .fifo_count(fifo_count), .full(full), .empty(empty), .idle(idle),
        .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // PRU responder: busy for busy_len cycles after start, then a one-cycle done
    always @(negedge clk) begin
        pru_done = 1'b0;
        if (!rst_n) begin
            pru_busy = 1'b0;
            cnt = 0;
        end else if (start) begin
            log_row[start_cnt] = row;
            log_cyc[start_cnt] = cyc;
            start_cnt++;
            pru_busy = 1'b1;
            cnt = busy_len;
        end else if (pru_busy && !never_done) begin
            cnt--;
            if (cnt <= 0) begin
                pru_busy = 1'b0;
                pru_done = 1'b1;
            end
        end
    end

    function automatic logic [31:0] w0(input logic [1:0] c, input logic [9:0] r,
                                       input logic [8:0] cl, input logic [9:0] w);
        return {1'b0, w, cl, r, c};
    endfunction

    function automatic logic [31:0] w1(input logic sub, input logic [1:0] ss, input logic [8:0] hr);
        return {20'h0, sub, ss, hr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        wr_en = 1'b1; wr_addr = 1'b0; wr_data = a;
        tick();
        wr_addr = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0; wr_addr = 1'b0; wr_data = '0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (!idle && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL %s idle got %b exp 1 after %0d cycles", name, idle, n);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({start, full, overflow, timeout_err, fifo_count} !== '0 || {empty, idle} !== 2'b11) begin
            errors++;
            $display("FAIL reset_status got start=%b full=%b ovf=%b to=%b cnt=%0d empty=%b idle=%b exp 0,0,0,0,0,1,1",
                     start, full, overflow, timeout_err, fifo_count, empty, idle);
        end
        checks++;
        if ({color, row, col, width, height_radius, shape_select, subtract} !== '0) begin
            errors++;
            $display("FAIL reset_fields got row=%0d col=%0d width=%0d exp all 0", row, col, width);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (idle !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got idle=%b start=%b exp 1 0", idle, start);
        end
    endtask

    task automatic test_rect();
        busy_len = 3;
        push(w0(2'd1, 10'd10, 9'd10, 10'd15), w1(1'b0, 2'd0, 9'd15));
        checks++;
        if (start !== 1'b0 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL rect_latency1 got start=%b cnt=%0d exp 0 1", start, fifo_count);
        end
        tick();
        checks++;
        if (start !== 1'b1 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL rect_start got start=%b cnt=%0d exp 1 0", start, fifo_count);
        end
        checks++;
        if ({color, row, col, width, height_radius, shape_select, subtract} !==
            {2'd1, 10'd10, 9'd10, 10'd15, 9'd15, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rect_fields got c=%0d r=%0d col=%0d w=%0d hr=%0d ss=%0d sub=%0d exp 1 10 10 15 15 0 0",
                     color, row, col, width, height_radius, shape_select, subtract);
        end
        tick();
        checks++;
        if (start !== 1'b0 || row !== 10'd10 || width !== 10'd15) begin
            errors++;
            $display("FAIL rect_hold got start=%b row=%0d width=%0d exp 0 10 15", start, row, width);
        end
        wait_idle(50, "rect_done");
    endtask

    task automatic test_backlog();
        int s0 = start_cnt;
        busy_len = 20;
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) push(w0(2'd2, 10'(i), 9'd5, 10'd6), w1(1'b1, 2'd1, 9'd7));
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("FAIL backlog_count3 got %0d exp 3", fifo_count);
        end
        hold = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 4'd2 || start !== 1'b1) begin
            errors++;
            $display("FAIL backlog_first got cnt=%0d start=%b exp 2 1", fifo_count, start);
        end
        wait_idle(300, "backlog_drain");
        checks++;
        if (start_cnt - s0 !== 3 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL backlog_starts got %0d cnt=%0d exp 3 0", start_cnt - s0, fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_row[s0 + i] !== 10'(i + 1)) begin
                errors++;
                $display("FAIL backlog_order[%0d] got row %0d exp %0d", i, log_row[s0 + i], i + 1);
            end
        end
        checks++;
        if (log_cyc[s0 + 1] - log_cyc[s0] !== 23) begin
            errors++;
            $display("FAIL backlog_gap got %0d exp 23", log_cyc[s0 + 1] - log_cyc[s0]);
        end
    endtask

    task automatic test_full();
        int s0 = start_cnt;
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(w0(2'd0, 10'(11 + i), 9'd1, 10'd1), w1(1'b0, 2'd2, 9'd3));
            if (i == 6) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_after7 got %b exp 0", full);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || fifo_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_after8 got full=%b cnt=%0d ovf=%b exp 1 8 0", full, fifo_count, overflow);
        end
        push(w0(2'd0, 10'd19, 9'd1, 10'd1), w1(1'b0, 2'd2, 9'd3));
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL full_overflow got ovf=%b cnt=%0d exp 1 8", overflow, fifo_count);
        end
        busy_len = 1;
        hold = 1'b0;
        wait_idle(500, "full_drain");
        checks++;
        if (start_cnt - s0 !== 8 || log_row[s0 + 7] !== 10'd18) begin
            errors++;
            $display("FAIL full_issued got %0d last_row=%0d exp 8 18", start_cnt - s0, log_row[s0 + 7]);
        end
        checks++;
        if (log_cyc[s0 + 1] - log_cyc[s0] !== 4) begin
            errors++;
            $display("FAIL min_spacing got %0d exp 4", log_cyc[s0 + 1] - log_cyc[s0]);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr got %b exp 0", overflow);
        end
    endtask

    task automatic test_flush();
        int s0 = start_cnt;
        busy_len = 30;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push(w0(2'd3, 10'(21 + i), 9'd2, 10'd2), w1(1'b0, 2'd0, 9'd4));
        hold = 1'b0;
        tick();
        checks++;
        if (start !== 1'b1 || fifo_count !== 4'd4) begin
            errors++;
            $display("FAIL flush_inflight got start=%b cnt=%0d exp 1 4", start, fifo_count);
        end
        hold = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        hold = 1'b0;
        checks++;
        if (fifo_count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_count got cnt=%0d empty=%b exp 0 1", fifo_count, empty);
        end
        wait_idle(200, "flush_complete");
        checks++;
        if (start_cnt - s0 !== 1 || log_row[s0] !== 10'd21 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_starts got %0d row=%0d to=%b exp 1 21 0", start_cnt - s0, log_row[s0], timeout_err);
        end
    endtask

    task automatic test_watchdog();
        int s0 = start_cnt;
        int n = 0;
        busy_len = 5;
        never_done = 1'b1;
        hold = 1'b1;
        push(w0(2'd1, 10'd31, 9'd3, 10'd3), w1(1'b0, 2'd1, 9'd5));
        push(w0(2'd1, 10'd32, 9'd3, 10'd3), w1(1'b0, 2'd1, 9'd5));
        hold = 1'b0;
        tick();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL wd_start got %b exp 1", start);
        end
        while (!timeout_err && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 51) begin
            errors++;
            $display("FAIL wd_latency got %0d exp 51", n);
        end
        n = 0;
        while (start_cnt - s0 < 2 && n < 10) begin
            tick();
            n++;
        end
        never_done = 1'b0;
        checks++;
        if (start_cnt - s0 !== 2 || log_row[s0 + 1] !== 10'd32 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_next got %0d row=%0d to=%b exp 2 32 1", start_cnt - s0, log_row[s0 + 1], timeout_err);
        end
        wait_idle(100, "wd_recover");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_clr got %b exp 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        busy_len = 40;
        hold = 1'b1;
        push(w0(2'd2, 10'd41, 9'd4, 10'd9), w1(1'b1, 2'd3, 9'd8));
        push(w0(2'd2, 10'd42, 9'd4, 10'd9), w1(1'b1, 2'd3, 9'd8));
        hold = 1'b0;
        repeat (6) tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({start, fifo_count, color, row, width, subtract} !== '0 || {empty, idle} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset got start=%b cnt=%0d row=%0d empty=%b idle=%b exp 0 0 0 1 1",
                     start, fifo_count, row, empty, idle);
        end
        tick();
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (4) tick();
        checks++;
        if (empty !== 1'b1 || idle !== 1'b1 || start_cnt !== s0) begin
            errors++;
            $display("FAIL reset_release got empty=%b idle=%b starts=%0d exp 1 1 0", empty, idle, start_cnt - s0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_rect();
        test_backlog();
        test_full();
        test_flush();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got no completion exp finish");
        $fatal(1);
    end
endmodule
